// File: rtl/bitty_control_unit.sv
// bitty_control_unit: multi-cycle sequencer for the Bitty core (load-S, ALU, write-back, branch, load/store).
// Define BITTY_LDST_EN to execute format-11 load/store; otherwise format 11 retires as a NOP.
module bitty_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        mem_ack,
  output logic [3:0]  mux_sel,
  output logic        en_s,
  output logic        en_c,
  output logic [2:0]  alu_sel,
  output logic [7:0]  en_reg,
  output logic        en_last,
  output logic        mem_req,
  output logic        mem_we,
  output logic        en_pc,
  output logic        done,
  output logic        busy
);
`ifdef BITTY_LDST_EN
  localparam logic ldst_en = 1'b1;
`else
  localparam logic ldst_en = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LD_S, ALU, WB, BR, MEM_A, MEM_D, MEM_END} state_t;
  state_t state, next_state, out_state;
  logic [15:0] ir;
  logic [2:0] rx, ry;
  logic [7:0] rx_hot;
  logic unused_bits;
  assign rx = ir[15:13];
  assign ry = ir[12:10];
  assign rx_hot = 8'b1 << rx;
  assign unused_bits = ^{ir[9:5], ir[1]};
  // Outputs are forced idle while reset is asserted so no write or retire can escape.
  assign out_state = reset ? IDLE : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == IDLE && run) ir <= instruction;
    end
  end
  always_comb begin
    next_state = state;
    mux_sel = 4'd0;
    en_s = 1'b0;
    en_c = 1'b0;
    alu_sel = 3'd0;
    en_reg = 8'd0;
    en_last = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    en_pc = 1'b0;
    done = 1'b0;
    busy = out_state != IDLE;
    case (out_state)
      IDLE: if (run) next_state = !instruction[1] ? LD_S : (instruction[0] && ldst_en) ? MEM_A : BR;
      LD_S: begin
        mux_sel = {1'b0, rx};
        en_s = 1'b1;
        next_state = ALU;
      end
      ALU: begin
        mux_sel = ir[0] ? 4'd8 : {1'b0, ry};
        en_c = 1'b1;
        alu_sel = ir[4:2];
        next_state = WB;
      end
      WB: begin
        mux_sel = 4'd10;
        en_reg = rx_hot;
        en_last = 1'b1;
        done = 1'b1;
        en_pc = 1'b1;
        next_state = IDLE;
      end
      MEM_A: begin
        mux_sel = {1'b0, ry};
        en_s = 1'b1;
        next_state = MEM_D;
      end
      MEM_D: begin
        mem_req = ldst_en;
        mem_we = ldst_en & ir[2];
        mux_sel = ir[2] ? {1'b0, rx} : 4'd9;
        en_reg = (!ir[2] && mem_ack) ? rx_hot : 8'd0;
        next_state = mem_ack ? MEM_END : MEM_D;
      end
      BR, MEM_END: begin
        done = 1'b1;
        en_pc = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bitty_control_unit.sv
// tb_bitty_control_unit: scoreboard bench; expected per-cycle output vectors are queued by the stimulus and popped by a monitor on busy cycles.
module tb_bitty_control_unit;
  logic clk, reset, run, mem_ack;
  logic [15:0] instruction;
  logic [3:0] mux_sel;
  logic en_s, en_c, en_last, mem_req, mem_we, en_pc, done, busy;
  logic [2:0] alu_sel;
  logic [7:0] en_reg;
  logic [22:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bitty_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction), .mem_ack(mem_ack),
    .mux_sel(mux_sel), .en_s(en_s), .en_c(en_c), .alu_sel(alu_sel), .en_reg(en_reg),
    .en_last(en_last), .mem_req(mem_req), .mem_we(mem_we), .en_pc(en_pc), .done(done), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [22:0] got_vec();
    return {mux_sel, en_s, en_c, alu_sel, en_reg, en_last, mem_req, mem_we, en_pc, done, busy};
  endfunction
  // Busy-cycle vector; en_pc and done always pulse together.
  function automatic logic [22:0] ev(logic [3:0] m, logic s, logic c, logic [2:0] a, logic [7:0] r,
                                     logic l, logic q, logic w, logic p);
    return {m, s, c, a, r, l, q, w, p, p, 1'b1};
  endfunction
  task automatic chk(input string name, input logic [22:0] got, input logic [22:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got=%h exp=%h", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && busy) begin
      if (exp_q.size() == 0) chk("unexpected_busy", got_vec(), 23'h0);
      else chk("seq", got_vec(), exp_q.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] ins);
    run = 1'b1;
    instruction = ins;
    step();
    run = 1'b0;
    instruction = 16'hFFFF;
  endtask
  task automatic idle_chk(input string name, input logic [22:0] mask);
    @(negedge clk);
    chk(name, got_vec() & mask, 23'h0);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    run = 1'b0;
    mem_ack = 1'b0;
    instruction = 16'h0000;
    repeat (2) step();
    reset = 1'b0;
    idle_chk("reset_state", '1);
    exp_q.push_back(ev(4'd1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd1, 0, 1, 3'd2, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd10, 0, 0, 3'd0, 8'h02, 1, 0, 0, 1));
    issue(16'h2408);
    repeat (3) step();
    exp_q.push_back(ev(4'd2, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd8, 0, 1, 3'd1, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd10, 0, 0, 3'd0, 8'h04, 1, 0, 0, 1));
    issue(16'h40A5);
    repeat (3) step();
    exp_q.push_back(ev(4'd0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1));
    run = 1'b1;
    instruction = 16'h0102;
    step();
    instruction = 16'h2408;
    step();
    run = 1'b0;
    idle_chk("idle_after_branch", '1);
`ifdef BITTY_LDST_EN
    exp_q.push_back(ev(4'd1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd9, 0, 0, 3'd0, 8'h00, 0, 1, 0, 0));
    exp_q.push_back(ev(4'd9, 0, 0, 3'd0, 8'h00, 0, 1, 0, 0));
    exp_q.push_back(ev(4'd9, 0, 0, 3'd0, 8'h08, 0, 1, 0, 0));
    exp_q.push_back(ev(4'd0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1));
    issue(16'h6403);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    exp_q.push_back(ev(4'd1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd3, 0, 0, 3'd0, 8'h00, 0, 1, 1, 0));
    exp_q.push_back(ev(4'd0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1));
    issue(16'h6407);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    exp_q.push_back(ev(4'd1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    issue(16'h6403);
    step();
    reset = 1'b1;
    mem_ack = 1'b1;
    idle_chk("reset_in_mem_d", 23'h003FD6);
    step();
    reset = 1'b0;
    mem_ack = 1'b0;
    idle_chk("after_reset_mem_d", '1);
`else
    exp_q.push_back(ev(4'd0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1));
    issue(16'h6403);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    idle_chk("idle_after_nop", '1);
`endif
    exp_q.push_back(ev(4'd1, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    issue(16'h2408);
    step();
    reset = 1'b1;
    idle_chk("reset_in_alu", 23'h003FC6);
    step();
    reset = 1'b0;
    idle_chk("after_reset_alu", '1);
    exp_q.push_back(ev(4'd2, 1, 0, 3'd0, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd8, 0, 1, 3'd1, 8'h00, 0, 0, 0, 0));
    exp_q.push_back(ev(4'd10, 0, 0, 3'd0, 8'h04, 1, 0, 0, 1));
    issue(16'h40A5);
    repeat (4) step();
    chk("queue_drained", 23'(exp_q.size()), 23'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
